// File: rtl/approx_error_monitor.sv
// Error-statistics collector for the 8-bit approximate adder: recomputes the exact sum,
// aligns it to the adder's register stage and accumulates error stats over a sample window.
module approx_error_monitor #(
  parameter int N_SAMPLES = 256,
  parameter int CNT_W     = 16,
  parameter int ACC_W     = 24
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       X,
  input  logic [7:0]       Y,
  input  logic [8:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] abs_err_sum,
  output logic [8:0]       max_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // accumulate width must hold a full 9-bit diff even when ACC_W is tiny
  localparam int SW = ((ACC_W > 9) ? ACC_W : 9) + 1;
  localparam logic [SW-1:0] ACC_MAX = (SW'(1) << ACC_W) - SW'(1);

  state_t            state;
  state_t            state_next;
  logic [8:0]        exact_d;
  logic              valid_d;
  logic              accept;
  logic              last_sample;
  logic signed [9:0] delta;
  logic signed [9:0] delta_neg;
  logic [8:0]        diff;
  logic [SW-1:0]     sum_wide;

  assign accept      = (state == RUN) && in_valid;
  assign last_sample = accept && (sample_count == CNT_W'(N_SAMPLES - 1));

  always_comb begin
    delta     = $signed({1'b0, exact_d}) - $signed({1'b0, approx_sum});
    delta_neg = -delta;
    diff      = delta[9] ? delta_neg[8:0] : delta[8:0];
    sum_wide  = SW'(abs_err_sum) + SW'(diff);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_sample) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The compare stage runs on valid_d regardless of state so the last sample lands in DRAIN.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      exact_d      <= '0;
      valid_d      <= 1'b0;
      sample_count <= '0;
      err_count    <= '0;
      abs_err_sum  <= '0;
      max_err      <= '0;
    end else if (state == IDLE && start) begin
      valid_d      <= 1'b0;
      sample_count <= '0;
      err_count    <= '0;
      abs_err_sum  <= '0;
      max_err      <= '0;
    end else begin
      if (accept) begin
        exact_d      <= {1'b0, X} + {1'b0, Y};
        valid_d      <= 1'b1;
        sample_count <= sample_count + CNT_W'(1);
      end else begin
        valid_d <= 1'b0;
      end
      if (valid_d) begin
        if (diff != 9'd0) err_count <= err_count + CNT_W'(1);
        abs_err_sum <= (sum_wide > ACC_MAX) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        if (diff > max_err) max_err <= diff;
      end
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor: table of 4-sample windows plus hand-written
// sequences for mid-window reset and a full 256-sample window.
module tb_approx_error_monitor;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  X = '0, Y = '0;
  logic [8:0]  approx_sum = '0;

  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [15:0] samples_a, samples_b, samples_c, errs_a, errs_b, errs_c;
  logic [23:0] abs_a, abs_c;
  logic [3:0]  abs_b;
  logic [8:0]  max_a, max_b, max_c;

  int          errors = 0;
  int          checks = 0;
  int          sel = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_at = 0;
  logic [8:0]  prev_approx = '0;

  logic        rd_busy, rd_done;
  logic [31:0] rd_samples, rd_errs, rd_abs, rd_max;

  always #5 clock = ~clock;

  approx_error_monitor #(.N_SAMPLES(4), .CNT_W(16), .ACC_W(24)) dut_a (
    .clock(clock), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .X(X), .Y(Y),
    .approx_sum(approx_sum), .busy(busy_a), .done(done_a), .sample_count(samples_a),
    .err_count(errs_a), .abs_err_sum(abs_a), .max_err(max_a));

  approx_error_monitor #(.N_SAMPLES(4), .CNT_W(16), .ACC_W(4)) dut_b (
    .clock(clock), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .X(X), .Y(Y),
    .approx_sum(approx_sum), .busy(busy_b), .done(done_b), .sample_count(samples_b),
    .err_count(errs_b), .abs_err_sum(abs_b), .max_err(max_b));

  approx_error_monitor #(.N_SAMPLES(256), .CNT_W(16), .ACC_W(24)) dut_c (
    .clock(clock), .rst_n(rst_n), .start(start_c), .in_valid(in_valid), .X(X), .Y(Y),
    .approx_sum(approx_sum), .busy(busy_c), .done(done_c), .sample_count(samples_c),
    .err_count(errs_c), .abs_err_sum(abs_c), .max_err(max_c));

  always_comb begin
    rd_busy = busy_a; rd_done = done_a;
    rd_samples = 32'(samples_a); rd_errs = 32'(errs_a); rd_abs = 32'(abs_a); rd_max = 32'(max_a);
    if (sel == 1) begin
      rd_busy = busy_b; rd_done = done_b;
      rd_samples = 32'(samples_b); rd_errs = 32'(errs_b); rd_abs = 32'(abs_b); rd_max = 32'(max_b);
    end else if (sel == 2) begin
      rd_busy = busy_c; rd_done = done_c;
      rd_samples = 32'(samples_c); rd_errs = 32'(errs_c); rd_abs = 32'(abs_c); rd_max = 32'(max_c);
    end
  end

  typedef struct {
    int              sel;
    logic            gaps;
    logic [3:0][7:0] x;
    logic [3:0][7:0] y;
    logic [3:0][8:0] approx;
    int              exp_samples;
    int              exp_errs;
    int              exp_abs;
    int              exp_max;
    int              exp_done_cyc;
  } window_t;

  window_t tests[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock: present a pair, feed the adder result of the previous pair, observe after the edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] x, input logic [7:0] y,
                               input logic [8:0] approx_next, input logic st);
    in_valid   = valid;
    X          = x;
    Y          = y;
    approx_sum = prev_approx;
    prev_approx = approx_next;
    start_a = (sel == 0) && st;
    start_b = (sel == 1) && st;
    start_c = (sel == 2) && st;
    @(posedge clock);
    #1;
    cyc++;
    if (rd_done) begin
      done_cnt++;
      done_at = cyc;
    end
  endtask

  task automatic beginWindow(input int which);
    sel = which;
    prev_approx = '0;
    cyc = 0;
    done_cnt = 0;
    done_at = 0;
    applyStimulus(1'b0, 8'h00, 8'h00, 9'd0, 1'b1);
    checkOutput("busy_after_start", 32'(rd_busy), 1);
  endtask

  initial begin
    // Entry 0 of each packed array is the first sample.
    tests[0] = '{0, 1'b0, {8'hFF, 8'h0F, 8'h01, 8'h00}, {8'hFF, 8'h01, 8'h01, 8'h00},
                 {9'd511, 9'd17, 9'd1, 9'd0}, 4, 3, 3, 1, 6};
    tests[1] = '{0, 1'b0, {8'h07, 8'h08, 8'h07, 8'h08}, {8'h08, 8'h07, 8'h08, 8'h07},
                 {9'd8, 9'd23, 9'd8, 9'd23}, 4, 4, 30, 8, 6};
    tests[2] = '{0, 1'b1, {8'hFF, 8'h03, 8'h80, 8'h10}, {8'h01, 8'h04, 8'h80, 8'h20},
                 {9'd256, 9'd10, 9'd0, 9'd48}, 4, 2, 259, 256, 9};
    tests[3] = '{1, 1'b0, {8'h10, 8'h10, 8'h10, 8'h10}, {8'h00, 8'h00, 8'h00, 8'h00},
                 {9'd9, 9'd9, 9'd9, 9'd9}, 4, 4, 15, 7, 6};

    #12;
    checkOutput("reset_busy", 32'(busy_a | busy_b | busy_c), 0);
    checkOutput("reset_done", 32'(done_a | done_b | done_c), 0);
    checkOutput("reset_samples", 32'(samples_a | samples_b | samples_c), 0);
    checkOutput("reset_errs", 32'(errs_a | errs_b | errs_c), 0);
    checkOutput("reset_abs", 32'(abs_a | abs_c) | 32'(abs_b), 0);
    checkOutput("reset_max", 32'(max_a | max_b | max_c), 0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Mid-window reset after two samples discards everything and never pulses done.
    beginWindow(0);
    applyStimulus(1'b1, 8'h20, 8'h01, 9'd40, 1'b0);
    applyStimulus(1'b1, 8'h05, 8'h05, 9'd3, 1'b0);
    checkOutput("pre_reset_samples", rd_samples, 2);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_busy", 32'(rd_busy), 0);
    checkOutput("midreset_samples", rd_samples, 0);
    checkOutput("midreset_errs", rd_errs, 0);
    checkOutput("midreset_abs", rd_abs, 0);
    checkOutput("midreset_max", rd_max, 0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h01, 8'h01, 9'd0, 1'b0);
    checkOutput("midreset_no_done", done_cnt, 0);
    checkOutput("midreset_idle_samples", rd_samples, 0);

    for (int t = 0; t < 4; t++) begin
      beginWindow(tests[t].sel);
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, tests[t].x[i], tests[t].y[i], tests[t].approx[i], 1'b0);
        if (tests[t].gaps) applyStimulus(1'b0, 8'hAA, 8'h55, 9'd0, 1'b1);
      end
      while (cyc < 16) applyStimulus(1'b0, 8'h00, 8'h00, 9'd0, 1'b0);
      checkOutput($sformatf("w%0d_done_pulses", t), done_cnt, 1);
      checkOutput($sformatf("w%0d_done_cycle", t), done_at, tests[t].exp_done_cyc);
      checkOutput($sformatf("w%0d_samples", t), rd_samples, tests[t].exp_samples);
      checkOutput($sformatf("w%0d_errs", t), rd_errs, tests[t].exp_errs);
      checkOutput($sformatf("w%0d_abs", t), rd_abs, tests[t].exp_abs);
      checkOutput($sformatf("w%0d_max", t), rd_max, tests[t].exp_max);
      checkOutput($sformatf("w%0d_busy_end", t), 32'(rd_busy), 0);
    end

    // Full default-size window with an exact adder.
    beginWindow(2);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a, b;
      a = 8'(i);
      b = 8'(i * 3);
      applyStimulus(1'b1, a, b, {1'b0, a} + {1'b0, b}, 1'b0);
    end
    while (cyc < 264) applyStimulus(1'b0, 8'h00, 8'h00, 9'd0, 1'b0);
    checkOutput("full_done_pulses", done_cnt, 1);
    checkOutput("full_done_cycle", done_at, 258);
    checkOutput("full_samples", rd_samples, 256);
    checkOutput("full_errs", rd_errs, 0);
    checkOutput("full_abs", rd_abs, 0);
    checkOutput("full_max", rd_max, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
